gemm_c_writer: RTL and testbench



---
 rtl/gemm_cwr_pkg.sv | 9 +
 rtl/gemm_cwr_fifo.sv | 55 +++++
 rtl/gemm_c_writer.sv | 119 +++++++++++
 tb/tb_gemm_c_writer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gemm_cwr_pkg.sv
// Shared constants and FSM state type for the Gemm C-tile writer.
package gemm_cwr_pkg;
    localparam int CWR_C_WIDTH    = 2048;
    localparam int CWR_BEAT_WIDTH = 512;
    localparam int CWR_BEATS      = CWR_C_WIDTH / CWR_BEAT_WIDTH;
    localparam int CWR_BEAT_BYTES = CWR_BEAT_WIDTH / 8;

    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/gemm_cwr_fifo.sv
// Tile FIFO: DEPTH entries of WIDTH bits, show-ahead read, flush that may
// capture a simultaneous push into the emptied buffer.
module gemm_cwr_fifo #(
    parameter int WIDTH = 2048,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= i_push ? ptr_inc('0) : '0;
            r_cnt <= CW'(i_push);
        end else begin
            if (i_push) r_wr <= ptr_inc(r_wr);
            if (i_pop)  r_rd <= ptr_inc(r_rd);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    // A flush restarts the write pointer, so a same-cycle push lands in slot 0.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_rst) r_mem[i_flush ? '0 : r_wr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
endmodule

// File: rtl/gemm_c_writer.sv
// Buffers Gemm result tiles and streams them as BEAT_WIDTH beats on a
// valid/ready port. Define GEMM_CWR_ADDR_EN to add per-beat byte addresses.
module gemm_c_writer
    import gemm_cwr_pkg::*;
#(
    parameter int C_WIDTH    = CWR_C_WIDTH,
    parameter int BEAT_WIDTH = CWR_BEAT_WIDTH,
    parameter int DEPTH      = 2
`ifdef GEMM_CWR_ADDR_EN
  , parameter int ADDR_WIDTH = 32
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_start,
`ifdef GEMM_CWR_ADDR_EN
    input  logic [ADDR_WIDTH-1:0] io_base_addr,
    input  logic [ADDR_WIDTH-1:0] io_stride,
`endif
    input  logic                  io_c_valid,
    input  logic [C_WIDTH-1:0]    io_c_in,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [BEAT_WIDTH-1:0] io_out_data,
    output logic                  io_out_last,
`ifdef GEMM_CWR_ADDR_EN
    output logic [ADDR_WIDTH-1:0] io_addr_out,
`endif
    output logic                  io_busy,
    output logic                  io_overflow,
    output logic [15:0]           io_tiles_done
);
    localparam int BEATS = C_WIDTH / BEAT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    state_t           r_state;
    logic [BW-1:0]    r_beat;
    logic             r_overflow;
    logic [15:0]      r_tiles_done;
    logic [C_WIDTH-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_last;
    logic             w_hs;
    logic             w_pop;
    logic             w_push;

    assign io_out_valid = (r_state == SEND);
    assign w_last = (r_beat == BW'(BEATS - 1));
    assign w_hs   = io_out_valid && io_out_ready;
    assign w_pop  = w_hs && w_last && !io_start;
    // A full FIFO still accepts a tile when its head leaves in the same cycle.
    assign w_push = io_c_valid && (io_start || !w_full || w_pop);

    gemm_cwr_fifo #(.WIDTH(C_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_flush (io_start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (io_c_in),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_overflow   <= 1'b0;
            r_tiles_done <= '0;
        end else if (io_start) begin
            r_state      <= io_c_valid ? SEND : IDLE;
            r_beat       <= '0;
            r_overflow   <= 1'b0;
            r_tiles_done <= '0;
        end else begin
            if (w_hs) r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_pop) r_tiles_done <= r_tiles_done + 16'd1;
            if (io_c_valid && !w_push) r_overflow <= 1'b1;
            case (r_state)
                IDLE: if (w_push) r_state <= SEND;
                SEND: if (w_pop && !w_push && w_count == CW'(1)) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_out_data   = io_out_valid ? w_head[int'(r_beat)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign io_out_last   = io_out_valid && w_last;
    assign io_busy       = !w_empty;
    assign io_overflow   = r_overflow;
    assign io_tiles_done = r_tiles_done;

`ifdef GEMM_CWR_ADDR_EN
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] r_tile_base;
    logic [ADDR_WIDTH-1:0] r_stride;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tile_base <= '0;
            r_stride    <= '0;
        end else if (io_start) begin
            r_tile_base <= io_base_addr;
            r_stride    <= io_stride;
        end else if (w_pop) begin
            r_tile_base <= r_tile_base + r_stride;
        end
    end

    assign io_addr_out = r_tile_base + ADDR_WIDTH'(int'(r_beat) * BEAT_BYTES);
`endif
endmodule

// File: tb/tb_gemm_c_writer.sv
// Directed table-driven bench for gemm_c_writer; address checks are active
// when GEMM_CWR_ADDR_EN is defined.
module tb_gemm_c_writer;
    logic          clock = 1'b0;
    logic          reset;
    logic          io_start;
    logic [31:0]   io_base_addr;
    logic [31:0]   io_stride;
    logic          io_c_valid;
    logic [2047:0] io_c_in;
    logic          io_out_valid;
    logic          io_out_ready;
    logic [511:0]  io_out_data;
    logic          io_out_last;
    logic [31:0]   io_addr_out;
    logic          io_busy;
    logic          io_overflow;
    logic [15:0]   io_tiles_done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    gemm_c_writer dut (
        .clock         (clock),
        .reset         (reset),
        .io_start      (io_start),
`ifdef GEMM_CWR_ADDR_EN
        .io_base_addr  (io_base_addr),
        .io_stride     (io_stride),
`endif
        .io_c_valid    (io_c_valid),
        .io_c_in       (io_c_in),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_data   (io_out_data),
        .io_out_last   (io_out_last),
`ifdef GEMM_CWR_ADDR_EN
        .io_addr_out   (io_addr_out),
`endif
        .io_busy       (io_busy),
        .io_overflow   (io_overflow),
        .io_tiles_done (io_tiles_done)
    );

`ifndef GEMM_CWR_ADDR_EN
    assign io_addr_out = '0;
`endif

    typedef struct {
        logic        start;
        logic        cv;
        int          id;
        logic        rdy;
        logic [31:0] base;
        logic [31:0] stride;
        logic        ev;
        int          eid;
        int          eb;
        logic        ebusy;
        logic        eovf;
        int          edone;
        logic [31:0] tbase;
    } vec_t;

    vec_t vq[$];
    logic [31:0] nb = '0;
    logic [31:0] ns = '0;

    // Tile 0 models a Gemm fed all-ones A/B (every element 8); others tag id and position.
    function automatic logic [2047:0] mk_tile(input int id);
        logic [2047:0] t;
        for (int j = 0; j < 64; j++)
            t[j*32 +: 32] = (id == 0) ? 32'd8 : {16'(id), 16'(j)};
        return t;
    endfunction

    function automatic logic [511:0] exp_beat(input int id, input int k);
        logic [2047:0] t;
        t = mk_tile(id);
        return t[k*512 +: 512];
    endfunction

    task automatic sb(input logic [31:0] b, input logic [31:0] s);
        nb = b;
        ns = s;
    endtask

    task automatic r(input logic st, input logic cv, input int id, input logic rdy,
                     input logic ev, input int eid, input int eb,
                     input logic busy, input logic ovf, input int done, input logic [31:0] tb);
        vec_t v;
        v.start = st; v.cv = cv; v.id = id; v.rdy = rdy; v.base = nb; v.stride = ns;
        v.ev = ev; v.eid = eid; v.eb = eb; v.ebusy = busy; v.eovf = ovf;
        v.edone = done; v.tbase = tb;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [511:0] act,
                       input logic [511:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s row %0d: got %0h want %0h", name, row, act, expv);
    endtask

    initial begin
        vec_t v;
        logic [31:0] ea;
        reset = 1'b1; io_start = 1'b0; io_c_valid = 1'b0; io_c_in = '0;
        io_out_ready = 1'b0; io_base_addr = '0; io_stride = '0;

        sb(32'h1000, 32'h100);
        r(1,0,0,1, 0,0,0, 0,0,0, 0);
        r(0,1,0,1, 0,0,0, 0,0,0, 0);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,0,k, 1,0,0, 32'h1000);
        r(0,1,1,1, 0,0,0, 0,0,1, 0);
        r(0,1,2,1, 1,1,0, 1,0,1, 32'h1100);
        for (int k = 1; k < 4; k++) r(0,0,0,1, 1,1,k, 1,0,1, 32'h1100);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,2,k, 1,0,2, 32'h1200);
        // ready pattern 1,0,0,1,0,0,1,0,1 across tile 3
        r(0,1,3,1, 0,0,0, 0,0,3, 0);
        r(0,0,0,1, 1,3,0, 1,0,3, 32'h1300);
        r(0,0,0,0, 1,3,1, 1,0,3, 32'h1300);
        r(0,0,0,0, 1,3,1, 1,0,3, 32'h1300);
        r(0,0,0,1, 1,3,1, 1,0,3, 32'h1300);
        r(0,0,0,0, 1,3,2, 1,0,3, 32'h1300);
        r(0,0,0,0, 1,3,2, 1,0,3, 32'h1300);
        r(0,0,0,1, 1,3,2, 1,0,3, 32'h1300);
        r(0,0,0,0, 1,3,3, 1,0,3, 32'h1300);
        r(0,0,0,1, 1,3,3, 1,0,3, 32'h1300);
        // three pushes with ready low: tile 6 is dropped
        r(0,1,4,0, 0,0,0, 0,0,4, 0);
        r(0,1,5,0, 1,4,0, 1,0,4, 32'h1400);
        r(0,1,6,0, 1,4,0, 1,0,4, 32'h1400);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,4,k, 1,1,4, 32'h1400);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,5,k, 1,1,5, 32'h1500);
        // new job; full FIFO push coincides with last-beat pop
        sb(32'h8000, 32'h40);
        r(1,0,0,0, 0,0,0, 0,1,6, 0);
        r(0,1,7,0, 0,0,0, 0,0,0, 0);
        r(0,1,8,1, 1,7,0, 1,0,0, 32'h8000);
        r(0,0,0,1, 1,7,1, 1,0,0, 32'h8000);
        r(0,0,0,1, 1,7,2, 1,0,0, 32'h8000);
        r(0,1,9,1, 1,7,3, 1,0,0, 32'h8000);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,8,k, 1,0,1, 32'h8040);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,9,k, 1,0,2, 32'h8080);
        // start at beat 2 with a simultaneous tile; new base wraps past 2^32
        r(0,1,10,1, 0,0,0, 0,0,3, 0);
        r(0,0,0,1, 1,10,0, 1,0,3, 32'h80C0);
        r(0,0,0,1, 1,10,1, 1,0,3, 32'h80C0);
        sb(32'hFFFF_FFC0, 32'h200);
        r(1,1,11,1, 1,10,2, 1,0,3, 32'h80C0);
        for (int k = 0; k < 4; k++) r(0,0,0,1, 1,11,k, 1,0,0, 32'hFFFF_FFC0);
        r(0,0,0,1, 0,0,0, 0,0,1, 0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", -1, 512'(io_out_valid), 512'd0);
        chk("rst_last",  -1, 512'(io_out_last), 512'd0);
        chk("rst_data",  -1, io_out_data, 512'd0);
        chk("rst_busy",  -1, 512'(io_busy), 512'd0);
        chk("rst_ovf",   -1, 512'(io_overflow), 512'd0);
        chk("rst_done",  -1, 512'(io_tiles_done), 512'd0);
`ifdef GEMM_CWR_ADDR_EN
        chk("rst_addr",  -1, 512'(io_addr_out), 512'd0);
`endif
        reset = 1'b0;

        foreach (vq[i]) begin
            @(negedge clock);
            v = vq[i];
            chk("valid", i, 512'(io_out_valid), 512'(v.ev));
            chk("last",  i, 512'(io_out_last), 512'(v.ev && v.eb == 3));
            chk("busy",  i, 512'(io_busy), 512'(v.ebusy));
            chk("ovf",   i, 512'(io_overflow), 512'(v.eovf));
            chk("done",  i, 512'(io_tiles_done), 512'(v.edone));
            if (v.ev) chk("data", i, io_out_data, exp_beat(v.eid, v.eb));
`ifdef GEMM_CWR_ADDR_EN
            ea = v.tbase + 32'(v.eb * 64);
            if (v.ev) chk("addr", i, 512'(io_addr_out), 512'(ea));
`else
            ea = '0;
`endif
            io_start = v.start; io_c_valid = v.cv; io_c_in = mk_tile(v.id);
            io_out_ready = v.rdy; io_base_addr = v.base; io_stride = v.stride;
        end

        // reset mid-tile clears everything on the next cycle
        @(negedge clock);
        io_start = 1'b0; io_c_valid = 1'b1; io_c_in = mk_tile(12); io_out_ready = 1'b1;
        @(negedge clock);
        chk("pre_rst_valid", -2, 512'(io_out_valid), 512'd1);
        chk("pre_rst_data",  -2, io_out_data, exp_beat(12, 0));
        io_c_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("midrst_valid", -3, 512'(io_out_valid), 512'd0);
        chk("midrst_busy",  -3, 512'(io_busy), 512'd0);
        chk("midrst_done",  -3, 512'(io_tiles_done), 512'd0);
        chk("midrst_last",  -3, 512'(io_out_last), 512'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_valid", -4, 512'(io_out_valid), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
